// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one sin/cos CORDIC engine between P_N clients.
// Latency: o_done pulses exactly P_LAT cycles after o_gnt; back-to-back job spacing P_LAT+P_GAP+1.
// Backpressure: clients hold i_req/i_theta until o_gnt; requests wait while BUSY/GAP, one job at a time.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_req, i_theta     per-client request level and packed signed angles (client k at [k*P_W +: P_W])
//   o_gnt, o_done      one-hot single-cycle pulses: angle accepted / result valid for that client
//   o_sin, o_cos       last captured result, held until the next completion
//   o_busy, o_err      not-IDLE indicator; sticky "engine ack low at latency expiry"
//   o_cordic_*         engine request level and angle; i_cordic_* engine results and ack
module cordic_arbiter #(
    parameter int P_N   = 4,
    parameter int P_W   = 20,
    parameter int P_LAT = 18,
    parameter int P_GAP = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [P_N-1:0]           i_req,
    input  logic [P_N*P_W-1:0]       i_theta,
    output logic [P_N-1:0]           o_gnt,
    output logic [P_N-1:0]           o_done,
    output logic signed [P_W-1:0]    o_sin,
    output logic signed [P_W-1:0]    o_cos,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_cordic_req,
    output logic signed [P_W-1:0]    o_cordic_theta,
    input  logic signed [P_W-1:0]    i_cordic_sin,
    input  logic signed [P_W-1:0]    i_cordic_cos,
    input  logic                     i_cordic_ack
);

    localparam int IW   = (P_N > 1) ? $clog2(P_N) : 1;
    localparam int CMAX = (P_LAT > P_GAP) ? P_LAT : P_GAP;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0]  LAT_END = CW'(P_LAT - 1);
    localparam logic [CW-1:0]  GAP_END = CW'(P_GAP - 1);
    localparam logic [IW-1:0]  PTR_RST = IW'(P_N - 1);
    localparam logic [P_N-1:0] ONE_HOT = {{(P_N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [IW-1:0]          ptr_q,    ptr_d;
    logic [IW-1:0]          idx_q,    idx_d;
    logic [CW-1:0]          cnt_q,    cnt_d;
    logic signed [P_W-1:0]  theta_q,  theta_d;
    logic [P_N-1:0]         gnt_q,    gnt_d;
    logic [P_N-1:0]         done_q,   done_d;
    logic signed [P_W-1:0]  sin_q,    sin_d;
    logic signed [P_W-1:0]  cos_q,    cos_d;
    logic                   err_q,    err_d;
    logic                   creq_q,   creq_d;

    // Unpack the client angles so the winner can be selected by index.
    logic signed [P_W-1:0]  theta_arr [P_N];
    for (genvar k = 0; k < P_N; k++) begin : g_unpack
        assign theta_arr[k] = i_theta[k*P_W +: P_W];
    end

    // Round-robin pick: scan from ptr+1 upward with wrap. The loop runs from the
    // farthest offset down to the nearest so the nearest requester is the last
    // (and therefore winning) assignment.
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = P_N; i >= 1; i--) begin
            scan_idx = IW'((int'(ptr_q) + i) % P_N);
            if (i_req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        theta_d = theta_q;
        gnt_d   = '0;
        done_d  = '0;
        sin_d   = sin_q;
        cos_d   = cos_q;
        err_d   = err_q;
        creq_d  = creq_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    theta_d = theta_arr[pick_idx];
                    idx_d   = pick_idx;
                    ptr_d   = pick_idx;
                    gnt_d   = ONE_HOT << pick_idx;
                    creq_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Completion is purely time-based: the engine ack is a level that
                // may still be high from the previous job, so it cannot mark the end.
                if (cnt_q == LAT_END) begin
                    sin_d   = i_cordic_sin;
                    cos_d   = i_cordic_cos;
                    done_d  = ONE_HOT << idx_q;
                    if (!i_cordic_ack) begin
                        err_d = 1'b1;
                    end
                    creq_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                // Hold the engine request low so the engine can clear its state.
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                creq_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            idx_q   <= '0;
            cnt_q   <= '0;
            theta_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            err_q   <= 1'b0;
            creq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            theta_q <= theta_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            err_q   <= err_d;
            creq_q  <= creq_d;
        end
    end

    assign o_gnt          = gnt_q;
    assign o_done         = done_q;
    assign o_sin          = sin_q;
    assign o_cos          = cos_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_err          = err_q;
    assign o_cordic_req   = creq_q;
    assign o_cordic_theta = theta_q;

endmodule
